// File: rtl/alu_share_ctrl.sv
// Round-robin sequencer sharing one combinational RV32I ALU between two request ports; legal op: accept->EXEC->RESP (rsp 2 cycles after accept), illegal: rsp 1 cycle after accept.
// Backpressure: RESP holds until rsp_ready and blocks all accepts; a new request may be accepted in the same cycle the response handshakes.
module alu_share_ctrl #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic [6:0]      req0_opcode,
    input  logic [2:0]      req0_funct3,
    input  logic [6:0]      req0_funct7,
    input  logic [XLEN-1:0] req0_rs1,
    input  logic [XLEN-1:0] req0_rs2,
    input  logic [XLEN-1:0] req0_imm,
    input  logic [4:0]      req0_rd,
    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic [6:0]      req1_opcode,
    input  logic [2:0]      req1_funct3,
    input  logic [6:0]      req1_funct7,
    input  logic [XLEN-1:0] req1_rs1,
    input  logic [XLEN-1:0] req1_rs2,
    input  logic [XLEN-1:0] req1_imm,
    input  logic [4:0]      req1_rd,
    output logic            alu_en,
    output logic [3:0]      alu_op,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    input  logic [XLEN-1:0] alu_result,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic            rsp_id,
    output logic [4:0]      rsp_rd,
    output logic [XLEN-1:0] rsp_data,
    output logic            rsp_illegal
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    typedef struct packed {
        logic       illegal;
        logic       use_imm;
        logic [3:0] op;
    } dec_t;

    typedef struct packed {
        logic [3:0]      op;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
    } alu_cmd_t;

    function automatic dec_t decode(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7);
        dec_t       d;
        logic [3:0] base;
        d.illegal = 1'b1;
        d.use_imm = 1'b0;
        d.op      = 4'd0;
        case (f3)
            3'd0:    base = 4'd0;
            3'd1:    base = 4'd2;
            3'd2:    base = 4'd3;
            3'd3:    base = 4'd4;
            3'd4:    base = 4'd5;
            3'd5:    base = 4'd6;
            3'd6:    base = 4'd8;
            default: base = 4'd9;
        endcase
        if (opc == 7'b0110011) begin
            if (f7 == 7'b0000000) begin
                d.illegal = 1'b0;
                d.op      = base;
            end else if (f7 == 7'b0100000 && f3 == 3'b000) begin
                d.illegal = 1'b0;
                d.op      = 4'd1;
            end else if (f7 == 7'b0100000 && f3 == 3'b101) begin
                d.illegal = 1'b0;
                d.op      = 4'd7;
            end
        end else if (opc == 7'b0010011) begin
            d.use_imm = 1'b1;
            if (f3 == 3'b001 || f3 == 3'b101) begin
                // Shift-immediates reuse funct7 as the arithmetic/logical selector.
                if (f7 == 7'b0000000) begin
                    d.illegal = 1'b0;
                    d.op      = base;
                end else if (f7 == 7'b0100000 && f3 == 3'b101) begin
                    d.illegal = 1'b0;
                    d.op      = 4'd7;
                end
            end else begin
                d.illegal = 1'b0;
                d.op      = base;
            end
        end
        return d;
    endfunction

    state_t          state_q, state_d;
    logic            ptr_q, ptr_d;
    alu_cmd_t        cmd_q, cmd_d;
    logic            rsp_id_q, rsp_id_d;
    logic [4:0]      rsp_rd_q, rsp_rd_d;
    logic [XLEN-1:0] rsp_data_q, rsp_data_d;
    logic            rsp_ill_q, rsp_ill_d;

    logic            accept, take, grant1;
    dec_t            dec0, dec1, sel_dec;
    logic [XLEN-1:0] sel_rs1, sel_opnd;
    logic [4:0]      sel_rd;

    always_comb begin
        accept = (state_q == IDLE) || (state_q == RESP && rsp_ready);
        grant1 = (req0_valid && req1_valid) ? ~ptr_q : req1_valid;
        take   = accept && (req0_valid || req1_valid);
        req0_ready = take && !grant1;
        req1_ready = take && grant1;
        dec0    = decode(req0_opcode, req0_funct3, req0_funct7);
        dec1    = decode(req1_opcode, req1_funct3, req1_funct7);
        sel_dec = grant1 ? dec1 : dec0;
        sel_rs1 = grant1 ? req1_rs1 : req0_rs1;
        sel_rd  = grant1 ? req1_rd : req0_rd;
        if (grant1) sel_opnd = dec1.use_imm ? req1_imm : req1_rs2;
        else        sel_opnd = dec0.use_imm ? req0_imm : req0_rs2;
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        cmd_d      = cmd_q;
        rsp_id_d   = rsp_id_q;
        rsp_rd_d   = rsp_rd_q;
        rsp_data_d = rsp_data_q;
        rsp_ill_d  = rsp_ill_q;
        case (state_q)
            EXEC: begin
                rsp_data_d = (rsp_rd_q == 5'd0) ? '0 : alu_result;
                rsp_ill_d  = 1'b0;
                state_d    = RESP;
            end
            RESP: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: ;
        endcase
        // A new accept overrides the IDLE return of a completed handshake.
        if (take) begin
            ptr_d    = grant1;
            rsp_id_d = grant1;
            rsp_rd_d = sel_rd;
            cmd_d.op = sel_dec.op;
            cmd_d.a  = sel_rs1;
            cmd_d.b  = sel_opnd;
            if (sel_dec.illegal) begin
                rsp_ill_d  = 1'b1;
                rsp_data_d = '0;
                state_d    = RESP;
            end else begin
                state_d = EXEC;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ptr_q      <= 1'b1;
            cmd_q      <= '0;
            rsp_id_q   <= 1'b0;
            rsp_rd_q   <= '0;
            rsp_data_q <= '0;
            rsp_ill_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            cmd_q      <= cmd_d;
            rsp_id_q   <= rsp_id_d;
            rsp_rd_q   <= rsp_rd_d;
            rsp_data_q <= rsp_data_d;
            rsp_ill_q  <= rsp_ill_d;
        end
    end

    assign alu_en      = (state_q == EXEC);
    assign alu_op      = alu_en ? cmd_q.op : '0;
    assign alu_a       = alu_en ? cmd_q.a : '0;
    assign alu_b       = alu_en ? cmd_q.b : '0;
    assign rsp_valid   = (state_q == RESP);
    assign rsp_id      = rsp_id_q;
    assign rsp_rd      = rsp_rd_q;
    assign rsp_data    = rsp_data_q;
    assign rsp_illegal = rsp_ill_q;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Bench for alu_share_ctrl: reference ALU, transaction-level scoreboard checked every cycle, directed vectors.
module tb_alu_share_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        r_v   [2];
    logic [6:0]  r_opc [2];
    logic [2:0]  r_f3  [2];
    logic [6:0]  r_f7  [2];
    logic [31:0] r_rs1 [2];
    logic [31:0] r_rs2 [2];
    logic [31:0] r_imm [2];
    logic [4:0]  r_rd  [2];
    logic        req0_ready, req1_ready;
    logic        alu_en;
    logic [3:0]  alu_op;
    logic [31:0] alu_a, alu_b, alu_result;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_illegal;
    logic [4:0]  rsp_rd;
    logic [31:0] rsp_data;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    alu_share_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(r_v[0]), .req0_ready(req0_ready), .req0_opcode(r_opc[0]), .req0_funct3(r_f3[0]),
        .req0_funct7(r_f7[0]), .req0_rs1(r_rs1[0]), .req0_rs2(r_rs2[0]), .req0_imm(r_imm[0]), .req0_rd(r_rd[0]),
        .req1_valid(r_v[1]), .req1_ready(req1_ready), .req1_opcode(r_opc[1]), .req1_funct3(r_f3[1]),
        .req1_funct7(r_f7[1]), .req1_rs1(r_rs1[1]), .req1_rs2(r_rs2[1]), .req1_imm(r_imm[1]), .req1_rd(r_rd[1]),
        .alu_en(alu_en), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_rd(rsp_rd),
        .rsp_data(rsp_data), .rsp_illegal(rsp_illegal)
    );

    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            4'd0: return a + b;
            4'd1: return a - b;
            4'd2: return a << b[4:0];
            4'd3: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd4: return (a < b) ? 32'd1 : 32'd0;
            4'd5: return a ^ b;
            4'd6: return a >> b[4:0];
            4'd7: return 32'($signed(a) >>> b[4:0]);
            4'd8: return a | b;
            4'd9: return a & b;
            default: return 32'd0;
        endcase
    endfunction

    assign alu_result = ref_alu(alu_op, alu_a, alu_b);

    typedef struct packed {
        logic       legal;
        logic       imm;
        logic [3:0] op;
    } mdec_t;

    localparam logic [3:0] BASE [8] = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};

    function automatic mdec_t m_dec(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7);
        mdec_t d;
        d.legal = 1'b0;
        d.imm   = 1'b0;
        d.op    = BASE[f3];
        if (opc == 7'h33) begin
            if (f7 == 7'h00) d.legal = 1'b1;
            else if (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)) begin
                d.legal = 1'b1;
                d.op    = (f3 == 3'd0) ? 4'd1 : 4'd7;
            end
        end else if (opc == 7'h13) begin
            d.imm   = 1'b1;
            d.legal = !(f3 == 3'd1 || f3 == 3'd5) || f7 == 7'h00 || (f3 == 3'd5 && f7 == 7'h20);
            if (f3 == 3'd5 && f7 == 7'h20) d.op = 4'd7;
        end
        return d;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard: at most one outstanding transaction with its accept cycle.
    int          cyc = 0;
    int          m_acc;
    logic        m_busy = 1'b0, m_last = 1'b1, m_legal, m_id;
    logic [3:0]  m_op;
    logic [31:0] m_a, m_b, m_data;
    logic [4:0]  m_rd;
    logic        g, can, anyv, exp_alu, exp_rv;
    mdec_t       md;

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            m_busy = 1'b0;
            m_last = 1'b1;
            chk("rst_alu_en", alu_en, 0);
            chk("rst_alu_op", alu_op, 0);
            chk("rst_alu_a", alu_a, 0);
            chk("rst_alu_b", alu_b, 0);
            chk("rst_rsp_valid", rsp_valid, 0);
            chk("rst_rsp_id", rsp_id, 0);
            chk("rst_rsp_rd", rsp_rd, 0);
            chk("rst_rsp_data", rsp_data, 0);
            chk("rst_rsp_illegal", rsp_illegal, 0);
            chk("rst_ready0", req0_ready, 0);
            chk("rst_ready1", req1_ready, 0);
        end else begin
            exp_alu = m_busy && m_legal && (cyc == m_acc + 1);
            chk("m_alu_en", alu_en, exp_alu);
            chk("m_alu_op", alu_op, exp_alu ? m_op : 4'd0);
            chk("m_alu_a", alu_a, exp_alu ? m_a : 32'd0);
            chk("m_alu_b", alu_b, exp_alu ? m_b : 32'd0);
            exp_rv = m_busy && (cyc >= m_acc + (m_legal ? 2 : 1));
            chk("m_rsp_valid", rsp_valid, exp_rv);
            if (exp_rv) begin
                chk("m_rsp_id", rsp_id, m_id);
                chk("m_rsp_rd", rsp_rd, m_rd);
                chk("m_rsp_data", rsp_data, m_data);
                chk("m_rsp_illegal", rsp_illegal, !m_legal);
            end
            can  = !m_busy || (exp_rv && rsp_ready);
            anyv = r_v[0] || r_v[1];
            g    = (r_v[0] && r_v[1]) ? ~m_last : r_v[1];
            chk("m_ready0", req0_ready, can && anyv && !g);
            chk("m_ready1", req1_ready, can && anyv && g);
            if (exp_rv && rsp_ready) m_busy = 1'b0;
            if (can && anyv) begin
                md      = m_dec(r_opc[g], r_f3[g], r_f7[g]);
                m_busy  = 1'b1;
                m_acc   = cyc;
                m_last  = g;
                m_id    = g;
                m_rd    = r_rd[g];
                m_legal = md.legal;
                m_op    = md.op;
                m_a     = r_rs1[g];
                m_b     = md.imm ? r_imm[g] : r_rs2[g];
                m_data  = (!md.legal || r_rd[g] == 5'd0) ? 32'd0 : ref_alu(md.op, m_a, m_b);
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int p, input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                           input logic [31:0] a, input logic [31:0] b, input logic [31:0] im, input logic [4:0] rd);
        r_v[p] = 1'b1; r_opc[p] = opc; r_f3[p] = f3; r_f7[p] = f7;
        r_rs1[p] = a; r_rs2[p] = b; r_imm[p] = im; r_rd[p] = rd;
    endtask

    task automatic clr_req(input int p);
        r_v[p] = 1'b0;
    endtask

    typedef struct {
        int          p;
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] a, b, im;
        logic [4:0]  rd;
        logic        ill;
        logic [31:0] d;
    } vec_t;

    vec_t vt [12];
    int   gq [$];
    int   w;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0]  = '{0, 7'h33, 3'd0, 7'h20, 32'd10, 32'd3, 32'd0, 5'd5, 1'b0, 32'd7};
        vt[1]  = '{1, 7'h33, 3'd2, 7'h00, 32'hFFFFFFFF, 32'd1, 32'd0, 5'd6, 1'b0, 32'd1};
        vt[2]  = '{0, 7'h33, 3'd3, 7'h00, 32'hFFFFFFFF, 32'd1, 32'd0, 5'd7, 1'b0, 32'd0};
        vt[3]  = '{1, 7'h13, 3'd4, 7'h55, 32'hF0F0F0F0, 32'd9, 32'hFFFFFFFF, 5'd8, 1'b0, 32'h0F0F0F0F};
        vt[4]  = '{0, 7'h13, 3'd1, 7'h00, 32'd1, 32'd9, 32'd31, 5'd9, 1'b0, 32'h80000000};
        vt[5]  = '{1, 7'h13, 3'd1, 7'h01, 32'd1, 32'd9, 32'd31, 5'd10, 1'b1, 32'd0};
        vt[6]  = '{0, 7'h03, 3'd2, 7'h00, 32'd4, 32'd4, 32'd4, 5'd11, 1'b1, 32'd0};
        vt[7]  = '{1, 7'h33, 3'd0, 7'h00, 32'd1, 32'd2, 32'd0, 5'd0, 1'b0, 32'd0};
        vt[8]  = '{0, 7'h13, 3'd7, 7'h00, 32'h12345678, 32'd0, 32'h0000FF00, 5'd12, 1'b0, 32'h00005600};
        vt[9]  = '{1, 7'h33, 3'd5, 7'h00, 32'h80000000, 32'd4, 32'd0, 5'd13, 1'b0, 32'h08000000};
        vt[10] = '{0, 7'h13, 3'd5, 7'h21, 32'd8, 32'd0, 32'd1, 5'd14, 1'b1, 32'd0};
        vt[11] = '{1, 7'h33, 3'd6, 7'h00, 32'h000000F0, 32'h0000000F, 32'd0, 5'd15, 1'b0, 32'h000000FF};

        rst_n = 1'b0;
        rsp_ready = 1'b1;
        for (int p = 0; p < 2; p++) begin
            r_v[p] = 1'b0; r_opc[p] = '0; r_f3[p] = '0; r_f7[p] = '0;
            r_rs1[p] = '0; r_rs2[p] = '0; r_imm[p] = '0; r_rd[p] = '0;
        end
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;
        tick;

        // Single ADD on port 0.
        set_req(0, 7'h33, 3'd0, 7'h00, 32'd5, 32'd7, 32'd0, 5'd3);
        @(negedge clk); chk("add_ready0", req0_ready, 1);
        tick; clr_req(0);
        @(negedge clk);
        chk("add_alu_en", alu_en, 1); chk("add_alu_op", alu_op, 0);
        chk("add_alu_a", alu_a, 5); chk("add_alu_b", alu_b, 7); chk("add_no_rsp_yet", rsp_valid, 0);
        tick;
        @(negedge clk);
        chk("add_rsp_valid", rsp_valid, 1); chk("add_data", rsp_data, 12);
        chk("add_id", rsp_id, 0); chk("add_rd", rsp_rd, 3); chk("add_ill", rsp_illegal, 0);
        tick;

        // SRAI on port 1: immediate operand, not rs2.
        set_req(1, 7'h13, 3'd5, 7'h20, 32'h80000000, 32'h99, 32'd4, 5'd7);
        @(negedge clk); chk("srai_ready1", req1_ready, 1);
        tick; clr_req(1);
        @(negedge clk); chk("srai_op", alu_op, 7); chk("srai_b", alu_b, 4);
        tick;
        @(negedge clk); chk("srai_data", rsp_data, 32'hF8000000); chk("srai_id", rsp_id, 1);
        tick;

        // Contention: both valid every cycle.
        set_req(0, 7'h33, 3'd0, 7'h00, 32'd100, 32'd1, 32'd0, 5'd1);
        set_req(1, 7'h33, 3'd4, 7'h00, 32'hAA, 32'h0F, 32'd0, 5'd2);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (req0_ready) gq.push_back(0);
            if (req1_ready) gq.push_back(1);
            tick;
        end
        clr_req(0); clr_req(1);
        chk("rr_accepts", gq.size(), 4);
        for (int k = 0; k < gq.size() && k < 4; k++) chk("rr_grant", gq[k], k % 2);
        tick; tick;

        // Illegal R-type on port 0.
        set_req(0, 7'h33, 3'd1, 7'h20, 32'd3, 32'd4, 32'd0, 5'd2);
        @(negedge clk); chk("ill_ready0", req0_ready, 1); chk("ill_alu_en0", alu_en, 0);
        tick; clr_req(0);
        @(negedge clk);
        chk("ill_rsp_valid", rsp_valid, 1); chk("ill_flag", rsp_illegal, 1);
        chk("ill_data", rsp_data, 0); chk("ill_alu_en1", alu_en, 0);
        tick;

        // Directed vector table.
        for (int n = 0; n < 12; n++) begin
            set_req(vt[n].p, vt[n].opc, vt[n].f3, vt[n].f7, vt[n].a, vt[n].b, vt[n].im, vt[n].rd);
            @(negedge clk);
            chk("vec_ready", vt[n].p ? req1_ready : req0_ready, 1);
            tick; clr_req(vt[n].p);
            w = 0;
            @(negedge clk);
            while (!rsp_valid && w < 4) begin
                w++;
                @(negedge clk);
            end
            chk("vec_rsp_valid", rsp_valid, 1);
            if (rsp_valid) begin
                chk("vec_data", rsp_data, vt[n].d);
                chk("vec_ill", rsp_illegal, vt[n].ill);
                chk("vec_id", rsp_id, vt[n].p);
            end
            tick;
        end

        // Backpressure for 5 cycles with a request waiting.
        rsp_ready = 1'b0;
        set_req(0, 7'h33, 3'd0, 7'h00, 32'd100, 32'd23, 32'd0, 5'd9);
        @(negedge clk); chk("bp_ready0", req0_ready, 1);
        tick; clr_req(0);
        tick;
        set_req(1, 7'h33, 3'd0, 7'h00, 32'd1, 32'd1, 32'd0, 5'd4);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid", rsp_valid, 1); chk("bp_data", rsp_data, 123); chk("bp_rd", rsp_rd, 9);
            chk("bp_ready0_low", req0_ready, 0); chk("bp_ready1_low", req1_ready, 0);
            tick;
        end
        rsp_ready = 1'b1;
        @(negedge clk); chk("bp_release_accept", req1_ready, 1); chk("bp_release_valid", rsp_valid, 1);
        tick; clr_req(1);
        tick;
        @(negedge clk); chk("bp_next_data", rsp_data, 2); chk("bp_next_id", rsp_id, 1);
        tick;

        // Reset asserted during EXEC; last grant was port 0 beforehand.
        set_req(0, 7'h33, 3'd0, 7'h00, 32'd40, 32'd2, 32'd0, 5'd6);
        @(negedge clk); chk("rstx_ready0", req0_ready, 1);
        tick; clr_req(0);
        #2 rst_n = 1'b0;
        @(negedge clk); chk("rstx_alu_en", alu_en, 0); chk("rstx_rsp_valid", rsp_valid, 0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); chk("rstx_no_stale", rsp_valid, 0);
        end
        tick;
        set_req(0, 7'h33, 3'd0, 7'h00, 32'd1, 32'd2, 32'd0, 5'd1);
        set_req(1, 7'h33, 3'd0, 7'h00, 32'd3, 32'd4, 32'd0, 5'd2);
        @(negedge clk); chk("rstx_win0", req0_ready, 1); chk("rstx_lose1", req1_ready, 0);
        tick; clr_req(0); clr_req(1);
        repeat (3) tick;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/alu_share_ctrl.md
# alu_share_ctrl

Sequencer and round-robin arbiter that shares the single combinational RV32I integer ALU between two requesters: port 0 is the main execute pipe, port 1 is the address/auxiliary pipe. Each accepted request is decoded from opcode/funct3/funct7 into an ALU operation. The block drives the ALU operands for exactly one cycle and captures the result. It returns the result with requester tag and destination register over a valid/ready response channel. It sits between the decode stage and writeback, and owns all operand muxing (register vs. immediate) in front of the ALU.

## Interface
- XLEN, 32, datapath width
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- reqN_valid (N=0,1)  in  1  request N present
- reqN_ready  out  1  request N accepted this cycle
- reqN_opcode  in  7  instruction opcode
- reqN_funct3  in  3  funct3
- reqN_funct7  in  7  funct7
- reqN_rs1  in  XLEN  source operand 1 value
- reqN_rs2  in  XLEN  source operand 2 value
- reqN_imm  in  XLEN  sign-extended immediate
- reqN_rd  in  5  destination register
- alu_en  out  1  ALU operands valid this cycle
- alu_op  out  4  0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND
- alu_a, alu_b  out  XLEN  ALU operands
- alu_result  in  XLEN  ALU result, combinational, same cycle
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_id  out  1  requester that issued the op
- rsp_rd  out  5  destination register
- rsp_data  out  XLEN  result
- rsp_illegal  out  1  op not decodable as R/I ALU op

## Operation
- FSM states: IDLE, EXEC, RESP.
  - IDLE: can accept a request.
  - EXEC: alu_en=1, alu_op/alu_a/alu_b driven from latched fields; alu_result registered at the clock edge.
  - RESP: rsp_valid=1; all rsp_* outputs held stable until rsp_ready.
- Accept condition: state IDLE, or state RESP with rsp_ready=1 (back-to-back accept).
- Arbitration: round-robin. The last-granted pointer resets to 1, so port 0 wins the first contention. With one requester valid, it is granted regardless of the pointer. The pointer updates only on accept.
- Ready: reqN_ready = accept condition AND grant to N. It is combinational from reqN_valid. At most one ready is high per cycle.
- Decoding for opcode 0110011 (R-type), with alu_b=rs2:
  - funct7 0000000 selects ADD/SLL/SLT/SLTU/XOR/SRL/OR/AND by funct3 000..111.
  - funct7 0100000 is legal only with funct3 000 (SUB) or 101 (SRA).
  - Any other funct7 is illegal.
- Decoding for opcode 0010011 (I-type), with alu_b=imm:
  - funct3 000/010/011/100/110/111 give ADDI/SLTI/SLTIU/XORI/ORI/ANDI; funct7 is ignored.
  - funct3 001 requires funct7=0000000.
  - funct3 101: funct7 0000000 gives SRLI, 0100000 gives SRAI, any other value is illegal.
- alu_a=rs1 always.
- Illegal op or any other opcode:
  - The FSM skips EXEC and goes IDLE→RESP; alu_en stays 0.
  - Response has rsp_illegal=1, rsp_data=0.
- rd=0: the ALU cycle still runs; rsp_data is forced to 0.
- Outside EXEC: alu_en=0, alu_op=0, alu_a=0, alu_b=0.

## Timing
- Reset (async assert, sync-safe release):
  - State IDLE, pointer=1.
  - rsp_valid=0, rsp_id=0, rsp_rd=0, rsp_data=0, rsp_illegal=0.
  - alu_* outputs 0; reqN_ready=0 (no valid during reset).
- Legal op accepted at cycle T: EXEC at T+1, rsp_valid=1 from T+2.
- Illegal op accepted at T: rsp_valid=1 from T+1.
- Throughput with rsp_ready tied high: one legal op per 2 cycles; accept happens on the RESP cycle.
- Backpressure: RESP is held indefinitely, no accepts occur, and both readies stay 0.
- Simultaneous events:
  - The RESP handshake and a new accept in the same cycle are both taken.
  - Next state is EXEC, or RESP for an illegal op.
  - rsp_valid drops for one cycle only when the next state is EXEC.
- Reset mid-operation: an in-flight op is discarded; no response is produced after release.

## Test plan
- Single req0 ADD, rs1=5, rs2=7, rd=3, ALU model = reference adder:
  - alu_en=1, alu_op=0, a=5, b=7 at T+1.
  - rsp_valid at T+2 with data=12, id=0, rd=3, illegal=0.
- req1 SRAI, rs1=0x80000000, imm=4, funct7=0100000, rsp_ready high:
  - alu_op=7, alu_b=4.
  - rsp_data=0xF8000000, id=1.
- Both valid every cycle, rsp_ready=1: grants alternate 0,1,0,1; first grant goes to 0; one accept every 2 cycles.
- Illegal R-type (funct3=001, funct7=0100000) on port 0:
  - alu_en never high.
  - rsp_valid at T+1, illegal=1, data=0.
- rsp_ready low for 5 cycles during RESP: rsp_* stable, req readies 0; on release, a pending request is accepted in the same cycle.
- rst_n asserted during EXEC: all outputs 0 immediately; after release, no stale response appears; the first contention is won by port 0.
